maxnet_iter_ctrl: RTL and testbench
===================================

Name: maxnet_iter_ctrl

Overview:
- Downstream stage of the 4-input processing unit (PU) array in the winner-take-all (Maxnet) datapath.
- Captures the four 12-bit PU results and applies ReLU, scaling and saturation to each.
- Feeds the four activations back to the PUs as their next-iteration 5-bit inputs.
- Iterates until exactly one neuron stays nonzero, then reports the winner index.
- PU weights (self/lateral inhibition) are driven externally, not by this block.

Parameters:
- PU_LATENCY, 2, cycles from PU input change to valid o_result (multiplier register plus output register).
- SHIFT, 3, arithmetic right-shift applied to each positive PU result.
- MAX_ITER, 15, iteration limit; used only when MAXNET_TIMEOUT_EN is defined.
- ITER_W, 4, width of iter_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset; takes effect on the rising edge of clk when low.
- start  in  1  one-cycle pulse; begins a run; ignored while busy.
- init_x0..init_x3  in  5 each  initial activations (signed, non-negative); sampled on start.
- pu_result0..pu_result3  in  12 each  signed results from the four PUs.
- pu_in0..pu_in3  out  5 each  registered activations driven to the PU inputs.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  level; high while in DONE.
- winner  out  2  index of the sole surviving neuron; valid when done is high.
- no_winner  out  1  high with done when all activations are zero or the run timed out.
- iter_count  out  ITER_W  number of completed UPDATE cycles in the current run.

Behaviour:
- Reset (rst low at a clock edge), also when asserted mid-run:
  - FSM goes to IDLE.
  - pu_in*, busy, done, winner, no_winner and iter_count all go to 0.
  - Wait counter cleared.
- FSM states: IDLE, WAIT, UPDATE, DONE.
- IDLE:
  - On start: pu_inN <= init_xN, iter_count <= 0, wait counter <= 0, go to WAIT.
- WAIT:
  - Counts PU_LATENCY cycles so pu_result* reflect the current pu_in*.
  - Goes to UPDATE when the counter reaches PU_LATENCY-1.
- UPDATE (one cycle):
  - For each N: if pu_resultN <= 0, aN = 0.
  - Otherwise v = pu_resultN >>> SHIFT, and aN = min(v, 15) as 5-bit unsigned magnitude with MSB 0.
  - pu_inN <= aN; iter_count increments (saturates at all-ones).
  - nz = count of nonzero aN, evaluated combinationally from the new values.
  - nz == 1: go to DONE, winner = index of the nonzero aN, no_winner = 0.
  - nz == 0: go to DONE, winner = 0, no_winner = 1.
  - nz >= 2 (ties included): clear the wait counter and return to WAIT.
  - Timeout check per Optional Feature; nz == 1 takes priority over timeout on the same cycle.
- DONE:
  - done = 1; winner, no_winner and pu_in* are held.
  - start restarts exactly as from IDLE; done drops in the same edge.
- start is ignored in WAIT and UPDATE.
- Total latency per iteration: PU_LATENCY + 1 cycles.

Optional Feature:
- MAXNET_TIMEOUT_EN defined:
  - In UPDATE, if nz >= 2 and iter_count (post-increment) == MAX_ITER, go to DONE with no_winner = 1 and winner = 0.
- Not defined:
  - No iteration limit; the run continues until nz <= 1.
  - MAX_ITER is unused.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/WAIT/UPDATE/DONE, 2 bits);
  - constants ACT_W = 5, RES_W = 12, ACT_MAX = 15.
- One sub-module: relu_sat, combinational.
  - Input: 12-bit signed. Output: 5-bit activation.
  - Performs ReLU, >>> SHIFT and clamp to 15.
  - Instantiated four times.

Test Plan:
- Bench wiring: PU array weights self = 8, others = -2; SHIFT = 3.
- init 10,6,3,1:
  - iteration 1: activations 7,2,0,0;
  - iteration 2: activations 6,0,0,0;
  - done with winner = 0, no_winner = 0, iter_count = 2.
- init 4,4,4,4:
  - iteration 1: activations 1,1,1,1;
  - iteration 2: activations 0,0,0,0;
  - done with no_winner = 1, iter_count = 2.
- Saturation, init 15,0,0,0:
  - PU result 120 gives 120 >>> 3 = 15;
  - done with winner = 0, iter_count = 1, pu_in0 = 15.
- Timeout, MAXNET_TIMEOUT_EN defined, MAX_ITER = 1, init 10,6,3,1:
  - done after 1 iteration with no_winner = 1;
  - without the macro, the same stimulus gives winner = 0 at iteration 2.
- Reset mid-run: rst low during WAIT of iteration 1:
  - next edge gives IDLE with all outputs 0;
  - a new start with 0,0,0,9 gives winner = 3.
- start pulsed while busy: no effect. start pulsed in DONE: rerun begins and done falls on that edge.

Source files
------------

// File: rtl/maxnet_iter_ctrl_pkg.sv
// Shared types and constants for the Maxnet iteration controller.
// Holds the FSM state encoding and the activation/result widths.
package maxnet_iter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int ACT_W   = 5;
    localparam int RES_W   = 12;
    localparam int ACT_MAX = 15;

endpackage

// File: rtl/maxnet_iter_ctrl_relu_sat.sv
// Combinational ReLU, arithmetic down-scale and clamp of one PU result
// into a non-negative activation for the next Maxnet iteration.
module relu_sat
    import maxnet_iter_ctrl_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  logic signed [RES_W-1:0] result,
    output logic        [ACT_W-1:0] act
);

    logic signed [RES_W-1:0] scaled;

    always_comb begin
        scaled = result >>> SHIFT;
        act    = '0;
        if (result > 0) begin
            if (scaled > RES_W'(ACT_MAX)) begin
                act = ACT_W'(ACT_MAX);
            end else begin
                act = scaled[ACT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/maxnet_iter_ctrl.sv
// Maxnet iteration controller: feeds activations back to the PU array until
// one neuron survives. Optional iteration limit under `MAXNET_TIMEOUT_EN.
module maxnet_iter_ctrl
    import maxnet_iter_ctrl_pkg::*;
#(
    parameter int PU_LATENCY = 2,
    parameter int SHIFT      = 3,
    parameter int MAX_ITER   = 15,
    parameter int ITER_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ACT_W-1:0]  init_x0,
    input  logic [ACT_W-1:0]  init_x1,
    input  logic [ACT_W-1:0]  init_x2,
    input  logic [ACT_W-1:0]  init_x3,
    input  logic [RES_W-1:0]  pu_result0,
    input  logic [RES_W-1:0]  pu_result1,
    input  logic [RES_W-1:0]  pu_result2,
    input  logic [RES_W-1:0]  pu_result3,
    output logic [ACT_W-1:0]  pu_in0,
    output logic [ACT_W-1:0]  pu_in1,
    output logic [ACT_W-1:0]  pu_in2,
    output logic [ACT_W-1:0]  pu_in3,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              no_winner,
    output logic [ITER_W-1:0] iter_count
);

`ifdef MAXNET_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int WAIT_W = (PU_LATENCY > 1) ? $clog2(PU_LATENCY) : 1;

    state_t             state_q, state_n;
    logic [WAIT_W-1:0]  wait_q, wait_n;
    logic [ITER_W-1:0]  iter_q, iter_n, iter_inc;
    logic [1:0]         winner_q, winner_n, win_idx;
    logic               nw_q, nw_n, timeout;
    logic [2:0]         nz;
    logic [ACT_W-1:0]   pu_in_q [4];
    logic [ACT_W-1:0]   pu_in_n [4];
    logic [ACT_W-1:0]   init_x  [4];
    logic [ACT_W-1:0]   act     [4];
    logic signed [RES_W-1:0] res [4];

    assign res[0] = pu_result0;
    assign res[1] = pu_result1;
    assign res[2] = pu_result2;
    assign res[3] = pu_result3;

    assign init_x[0] = init_x0;
    assign init_x[1] = init_x1;
    assign init_x[2] = init_x2;
    assign init_x[3] = init_x3;

    for (genvar g = 0; g < 4; g++) begin : g_relu
        relu_sat #(.SHIFT(SHIFT)) u_relu_sat (
            .result (res[g]),
            .act    (act[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            iter_q   <= '0;
            winner_q <= '0;
            nw_q     <= 1'b0;
            pu_in_q  <= '{default: '0};
        end else begin
            state_q  <= state_n;
            wait_q   <= wait_n;
            iter_q   <= iter_n;
            winner_q <= winner_n;
            nw_q     <= nw_n;
            pu_in_q  <= pu_in_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        wait_n   = wait_q;
        iter_n   = iter_q;
        winner_n = winner_q;
        nw_n     = nw_q;
        pu_in_n  = pu_in_q;

        // Survivor count and index come from the fresh activations, not pu_in_q.
        nz      = '0;
        win_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (act[i] != '0) begin
                nz      = nz + 3'd1;
                win_idx = 2'(i);
            end
        end

        iter_inc = (iter_q == '1) ? iter_q : iter_q + 1'b1;
        timeout  = TIMEOUT_EN && (iter_inc == ITER_W'(MAX_ITER));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pu_in_n = init_x;
                    iter_n  = '0;
                    wait_n  = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == WAIT_W'(PU_LATENCY - 1)) begin
                    state_n = UPDATE;
                end else begin
                    wait_n = wait_q + 1'b1;
                end
            end
            UPDATE: begin
                pu_in_n = act;
                iter_n  = iter_inc;
                if (nz == 3'd1) begin
                    state_n  = DONE;
                    winner_n = win_idx;
                    nw_n     = 1'b0;
                end else if (nz == 3'd0 || timeout) begin
                    state_n  = DONE;
                    winner_n = '0;
                    nw_n     = 1'b1;
                end else begin
                    wait_n  = '0;
                    state_n = WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state_q == WAIT) || (state_q == UPDATE);
    assign done       = (state_q == DONE);
    assign winner     = winner_q;
    assign no_winner  = nw_q;
    assign iter_count = iter_q;
    assign pu_in0     = pu_in_q[0];
    assign pu_in1     = pu_in_q[1];
    assign pu_in2     = pu_in_q[2];
    assign pu_in3     = pu_in_q[3];

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Directed bench for maxnet_iter_ctrl with a 2-cycle PU array model
// (self weight 8, lateral weight -2). Honours `MAXNET_TIMEOUT_EN.
module tb_maxnet_iter_ctrl;

    localparam int MAX_ITER = 1;

`ifdef MAXNET_TIMEOUT_EN
    localparam logic [3:0]  CONV_ITER = 4'd1;
    localparam logic        CONV_NW   = 1'b1;
    localparam logic [19:0] CONV_ACT  = {5'd7, 5'd2, 5'd0, 5'd0};
    localparam logic [3:0]  ZERO_ITER = 4'd1;
    localparam logic [19:0] ZERO_ACT  = {5'd1, 5'd1, 5'd1, 5'd1};
`else
    localparam logic [3:0]  CONV_ITER = 4'd2;
    localparam logic        CONV_NW   = 1'b0;
    localparam logic [19:0] CONV_ACT  = {5'd6, 5'd0, 5'd0, 5'd0};
    localparam logic [3:0]  ZERO_ITER = 4'd2;
    localparam logic [19:0] ZERO_ACT  = {5'd0, 5'd0, 5'd0, 5'd0};
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  init_x0 = '0, init_x1 = '0, init_x2 = '0, init_x3 = '0;
    logic [4:0]  pu_in0, pu_in1, pu_in2, pu_in3;
    logic        busy, done, no_winner;
    logic [1:0]  winner;
    logic [3:0]  iter_count;

    logic [4:0]         pin [4];
    logic signed [11:0] s1 [4] = '{default: '0};
    logic signed [11:0] s2 [4] = '{default: '0};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign pin[0] = pu_in0;
    assign pin[1] = pu_in1;
    assign pin[2] = pu_in2;
    assign pin[3] = pu_in3;

    function automatic logic signed [11:0] pu_calc(input int i);
        int sum = 0;
        for (int j = 0; j < 4; j++)
            sum += (j == i) ? 8 * int'(pin[j]) : -2 * int'(pin[j]);
        return 12'(sum);
    endfunction

    // Two-stage PU pipeline: multiplier register then output register.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            s1[i] <= pu_calc(i);
            s2[i] <= s1[i];
        end
    end

    maxnet_iter_ctrl #(
        .PU_LATENCY (2),
        .SHIFT      (3),
        .MAX_ITER   (MAX_ITER),
        .ITER_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_x0    (init_x0),
        .init_x1    (init_x1),
        .init_x2    (init_x2),
        .init_x3    (init_x3),
        .pu_result0 (s2[0]),
        .pu_result1 (s2[1]),
        .pu_result2 (s2[2]),
        .pu_result3 (s2[3]),
        .pu_in0     (pu_in0),
        .pu_in1     (pu_in1),
        .pu_in2     (pu_in2),
        .pu_in3     (pu_in3),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .no_winner  (no_winner),
        .iter_count (iter_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [4:0] a, b, c, d);
        init_x0 = a; init_x1 = b; init_x2 = c; init_x3 = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({pu_in0, pu_in1, pu_in2, pu_in3, busy, done, winner, no_winner, iter_count} !== 30'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {pu_in0, pu_in1, pu_in2, pu_in3, busy, done, winner, no_winner, iter_count});
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_converge();
        start_run(5'd10, 5'd6, 5'd3, 5'd1);
        n_checks++;
        if ({busy, done, iter_count} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL conv_start_flags: got %b expected %b", {busy, done, iter_count}, 6'b100000);
        else n_pass++;
        n_checks++;
        if ({pu_in0, pu_in1, pu_in2, pu_in3} !== {5'd10, 5'd6, 5'd3, 5'd1})
            $display("FAIL conv_load: got %h expected %h", {pu_in0, pu_in1, pu_in2, pu_in3},
                     {5'd10, 5'd6, 5'd3, 5'd1});
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (iter_count !== 4'd0)
            $display("FAIL conv_latency: iter_count %0d expected 0 before third edge", iter_count);
        else n_pass++;
        tick();
        n_checks++;
        if ({iter_count, pu_in0, pu_in1, pu_in2, pu_in3} !== {4'd1, 5'd7, 5'd2, 5'd0, 5'd0})
            $display("FAIL conv_iter1: got %h expected %h", {iter_count, pu_in0, pu_in1, pu_in2, pu_in3},
                     {4'd1, 5'd7, 5'd2, 5'd0, 5'd0});
        else n_pass++;
`ifndef MAXNET_TIMEOUT_EN
        n_checks++;
        if ({busy, done} !== 2'b10)
            $display("FAIL conv_iter1_busy: got %b expected 10", {busy, done});
        else n_pass++;
        tick();
        tick();
        tick();
`endif
        n_checks++;
        if ({pu_in0, pu_in1, pu_in2, pu_in3} !== CONV_ACT)
            $display("FAIL conv_final_act: got %h expected %h", {pu_in0, pu_in1, pu_in2, pu_in3}, CONV_ACT);
        else n_pass++;
        n_checks++;
        if ({done, busy, winner, no_winner, iter_count} !== {1'b1, 1'b0, 2'd0, CONV_NW, CONV_ITER})
            $display("FAIL conv_result: got %b expected %b", {done, busy, winner, no_winner, iter_count},
                     {1'b1, 1'b0, 2'd0, CONV_NW, CONV_ITER});
        else n_pass++;
    endtask

    task automatic test_restart_from_done();
        bit ok;
        start_run(5'd0, 5'd0, 5'd0, 5'd9);
        n_checks++;
        if ({done, busy, iter_count, pu_in0, pu_in1, pu_in2, pu_in3} !==
            {1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 5'd9})
            $display("FAIL restart_edge: got %h expected %h",
                     {done, busy, iter_count, pu_in0, pu_in1, pu_in2, pu_in3},
                     {1'b0, 1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 5'd9});
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok || {winner, no_winner, iter_count} !== {2'd3, 1'b0, 4'd1})
            $display("FAIL restart_result: done %b got %b expected %b", ok,
                     {winner, no_winner, iter_count}, {2'd3, 1'b0, 4'd1});
        else n_pass++;
    endtask

    task automatic test_all_zero();
        bit ok;
        start_run(5'd4, 5'd4, 5'd4, 5'd4);
        tick();
        tick();
        tick();
        n_checks++;
        if ({iter_count, pu_in0, pu_in1, pu_in2, pu_in3} !== {4'd1, 5'd1, 5'd1, 5'd1, 5'd1})
            $display("FAIL zero_iter1: got %h expected %h", {iter_count, pu_in0, pu_in1, pu_in2, pu_in3},
                     {4'd1, 5'd1, 5'd1, 5'd1, 5'd1});
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok || {winner, no_winner, iter_count, pu_in0, pu_in1, pu_in2, pu_in3} !==
            {2'd0, 1'b1, ZERO_ITER, ZERO_ACT})
            $display("FAIL zero_result: done %b got %h expected %h", ok,
                     {winner, no_winner, iter_count, pu_in0, pu_in1, pu_in2, pu_in3},
                     {2'd0, 1'b1, ZERO_ITER, ZERO_ACT});
        else n_pass++;
    endtask

    task automatic test_saturation();
        start_run(5'd15, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        tick();
        n_checks++;
        if ({done, winner, no_winner, iter_count, pu_in0, pu_in1, pu_in2, pu_in3} !==
            {1'b1, 2'd0, 1'b0, 4'd1, 5'd15, 5'd0, 5'd0, 5'd0})
            $display("FAIL sat_result: got %h expected %h",
                     {done, winner, no_winner, iter_count, pu_in0, pu_in1, pu_in2, pu_in3},
                     {1'b1, 2'd0, 1'b0, 4'd1, 5'd15, 5'd0, 5'd0, 5'd0});
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if ({done, busy, winner, no_winner, iter_count, pu_in0} !== {1'b1, 1'b0, 2'd0, 1'b0, 4'd1, 5'd15})
            $display("FAIL sat_hold: got %h expected %h", {done, busy, winner, no_winner, iter_count, pu_in0},
                     {1'b1, 1'b0, 2'd0, 1'b0, 4'd1, 5'd15});
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        bit ok;
        start_run(5'd10, 5'd6, 5'd3, 5'd1);
        start_run(5'd15, 5'd0, 5'd0, 5'd0);
        n_checks++;
        if ({busy, iter_count, pu_in0, pu_in1, pu_in2, pu_in3} !== {1'b1, 4'd0, 5'd10, 5'd6, 5'd3, 5'd1})
            $display("FAIL busy_start_wait: got %h expected %h",
                     {busy, iter_count, pu_in0, pu_in1, pu_in2, pu_in3},
                     {1'b1, 4'd0, 5'd10, 5'd6, 5'd3, 5'd1});
        else n_pass++;
        tick();
        start_run(5'd0, 5'd0, 5'd0, 5'd9);
        n_checks++;
        if ({iter_count, pu_in0, pu_in1, pu_in2, pu_in3} !== {4'd1, 5'd7, 5'd2, 5'd0, 5'd0})
            $display("FAIL busy_start_update: got %h expected %h",
                     {iter_count, pu_in0, pu_in1, pu_in2, pu_in3}, {4'd1, 5'd7, 5'd2, 5'd0, 5'd0});
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok || {winner, no_winner, iter_count} !== {2'd0, CONV_NW, CONV_ITER})
            $display("FAIL busy_result: done %b got %b expected %b", ok,
                     {winner, no_winner, iter_count}, {2'd0, CONV_NW, CONV_ITER});
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        start_run(5'd10, 5'd6, 5'd3, 5'd1);
        rst = 1'b0;
        tick();
        n_checks++;
        if ({pu_in0, pu_in1, pu_in2, pu_in3, busy, done, winner, no_winner, iter_count} !== 30'd0)
            $display("FAIL midrun_reset: got %h expected 0",
                     {pu_in0, pu_in1, pu_in2, pu_in3, busy, done, winner, no_winner, iter_count});
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL midrun_idle: got %b expected 00", {busy, done});
        else n_pass++;
        start_run(5'd0, 5'd0, 5'd0, 5'd9);
        wait_done(ok);
        n_checks++;
        if (!ok || {winner, no_winner, iter_count, pu_in3} !== {2'd3, 1'b0, 4'd1, 5'd9})
            $display("FAIL midrun_rerun: done %b got %h expected %h", ok,
                     {winner, no_winner, iter_count, pu_in3}, {2'd3, 1'b0, 4'd1, 5'd9});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_converge();
        test_restart_from_done();
        test_all_zero();
        test_saturation();
        test_start_while_busy();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
